// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned) for the EX-stage ALU.
// Define DIV_EARLY_OUT_EN to finish immediately on divide-by-zero or |x| < |y|.
module iter_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             div_clk,
  input  logic             reset,
  input  logic             div,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             div_complete
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZEROS = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] ay;
  logic             sign_q;
  logic             sign_r;
  logic             dz;

  logic [WIDTH-1:0] ax_in;
  logic [WIDTH-1:0] ay_in;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             last_iter;

  assign ax_in     = (div_signed && x[WIDTH-1]) ? (~x + ONE) : x;
  assign ay_in     = (div_signed && y[WIDTH-1]) ? (~y + ONE) : y;
  assign last_iter = (cnt == LAST);

`ifdef DIV_EARLY_OUT_EN
  logic early;
  assign early = (y == ZEROS) || (ax_in < ay_in);
`endif

  // One restoring step. Because rem < |y| holds between steps, a (WIDTH+1)-bit
  // subtract is enough and its MSB is the borrow.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    trial  = rem_sh - {1'b0, ay};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_sh[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
    if (dz) begin
      q_fix = ONES;
    end else if (sign_q) begin
      q_fix = ~quo_next + ONE;
    end else begin
      q_fix = quo_next;
    end
    if (sign_r) begin
      r_fix = ~rem_next + ONE;
    end else begin
      r_fix = rem_next;
    end
  end

  // State register
  always_ff @(posedge div_clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE: begin
        if (div) begin
`ifdef DIV_EARLY_OUT_EN
          if (early) begin
            next_state = DONE;
          end else begin
            next_state = ITER;
          end
`else
          next_state = ITER;
`endif
        end else begin
          next_state = IDLE;
        end
      end
      ITER: begin
        if (!div) begin
          next_state = IDLE;
        end else if (last_iter) begin
          next_state = DONE;
        end else begin
          next_state = ITER;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    div_complete = (state == DONE);
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge div_clk) begin
    if (reset) begin
      cnt    <= {CNT_W{1'b0}};
      rem    <= ZEROS;
      quo    <= ZEROS;
      ay     <= ZEROS;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      dz     <= 1'b0;
      s      <= ZEROS;
      r      <= ZEROS;
    end else begin
      case (state)
        IDLE: begin
          if (div) begin
            cnt    <= {CNT_W{1'b0}};
            rem    <= ZEROS;
            quo    <= ax_in;
            ay     <= ay_in;
            sign_q <= div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
            sign_r <= div_signed & x[WIDTH-1];
            dz     <= (y == ZEROS);
`ifdef DIV_EARLY_OUT_EN
            if (early) begin
              s <= (y == ZEROS) ? ONES : ZEROS;
              r <= x;
            end
`endif
          end
        end
        ITER: begin
          if (div) begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + CNT_W'(1);
            if (last_iter) begin
              s <= q_fix;
              r <= r_fix;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle radix-2 restoring divider; the responder on the ALU's divide request interface (div / div_signed / x / y → s / r / div_complete).
- Sits inside the EX-stage ALU. The ALU holds div high and stalls EX until div_complete is asserted, then uses s for div/divu and r for mod/modu.
- Replaces the ALU's inline divide path with a self-contained, verifiable unit.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- div_clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- div  in  1  request; level, held high by initiator until div_complete
- div_signed  in  1  1 = signed (div.w/mod.w), 0 = unsigned; sampled with div in IDLE
- x  in  WIDTH  dividend; sampled in IDLE
- y  in  WIDTH  divisor; sampled in IDLE
- s  out  WIDTH  quotient, registered
- r  out  WIDTH  remainder, registered
- div_complete  out  1  one-cycle done pulse; s/r valid in the same cycle

Behaviour:
- Reset:
  - One clock, div_clk. Reset is synchronous and active-high (already decided).
  - reset=1 at a clock edge: state→IDLE, counter→0, s→0, r→0, div_complete=0.
  - Reset mid-operation aborts with no completion pulse.
- States: IDLE, ITER, DONE.
- IDLE:
  - div=1 at an edge: latch |x|, |y| (abs only if div_signed), sign_q = div_signed&(x[W-1]^y[W-1]), sign_r = div_signed&x[W-1], dz = (y==0). Counter←0. →ITER.
  - Operands are captured only here; later changes to x/y are ignored.
- ITER:
  - Each cycle: partial remainder {rem,quo} shifted left 1; trial = rem_shifted − |y|.
  - Trial non-negative (33-bit subtract, no borrow): rem←trial, quotient bit=1; else restore, bit=0.
  - Counter increments. After WIDTH iterations → DONE.
- DONE:
  - On entry, s/r registers are loaded with sign-fixed results: s = sign_q ? −q : q; r = sign_r ? −rem : rem.
  - div_complete=1 combinationally for exactly this one cycle.
  - → IDLE unconditionally.
- Latency:
  - div first seen high at edge 0 → div_complete high in cycle WIDTH+1 (33 for WIDTH=32).
  - s/r hold their value until the next DONE or reset.
- Back-to-back: if div is still high in IDLE the cycle after DONE, a new operation starts. No bubble beyond the IDLE sample cycle.
- Abort: div=0 sampled in ITER → IDLE next edge. No div_complete; s/r unchanged. Covers exception/flush of the initiator.
- Divide by zero (dz=1): after normal latency, s=all ones, r=x (original, unsigned view), regardless of div_signed. No trap.
- Signed overflow x=0x80000000, y=0xFFFFFFFF: s=0x80000000, r=0 (falls out of 33-bit abs arithmetic; must not be special-cased wrong).
- Remainder sign follows dividend; quotient truncates toward zero.
- div_complete is never high outside DONE; never two consecutive cycles.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if dz or |x|<|y| (unsigned compare of latched abs values), go IDLE→DONE directly; div_complete in cycle 1.
  - dz gives s=all ones, r=x.
  - |x|<|y| gives s=0, r=x (sign-correct since sign_r follows x).
- Not defined: every operation takes the full WIDTH+1 latency; the compare logic is absent.

Test Plan:
- Unsigned: div=1, div_signed=0, x=0xFFFFFFFF, y=0x10 → cycle 33: div_complete=1, s=0x0FFFFFFF, r=0xF; cycle 34 complete=0.
- Signed: x=0xFFFFFFF9 (−7), y=2 → s=0xFFFFFFFD, r=0xFFFFFFFF. Then x=7, y=0xFFFFFFFE → s=0xFFFFFFFD, r=1.
- Overflow/zero: signed x=0x80000000, y=0xFFFFFFFF → s=0x80000000, r=0. Then x=0x1234, y=0 → s=0xFFFFFFFF, r=0x1234.
- Abort/reset: start x=100, y=7, drop div at cycle 10 → no complete, state IDLE, s/r keep prior values. Restart, assert reset at cycle 20 → s=r=0, no complete.
- Back-to-back: hold div high across two ops (100/7, then x=50, y=5 presented after first complete) → completes at 33 and 67; s=14,r=2 then s=10,r=0.
- DIV_EARLY_OUT_EN: x=3, y=9 → complete at cycle 1, s=0, r=3. Without macro → complete at cycle 33, same values.
